// File: rtl/tulip_dsp_pkg.sv
// tulip_dsp_pkg: shared FIR tap-load types and default table geometry
package tulip_dsp_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, DONE} tap_strm_state_t;
  localparam int TAP_WIDTH     = 16;
  localparam int NUM_TAPS_LOG2 = 4;
endpackage

// File: rtl/tap_table_regs.sv
// tap_table_regs: coefficient flop array, one write port, combinational read, async clear
module tap_table_regs #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [2**AW];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    else if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_tap_streamer.sv
// fir_tap_streamer: streams the host tap table to the FIR tap-load port and reports done/timeout.
// Defining FIR_TAP_STREAMER_CHECKSUM_EN adds the per-load checksum output.
module fir_tap_streamer
  import tulip_dsp_pkg::*;
#(
  parameter int G_TAP_WIDTH      = TAP_WIDTH,
  parameter int G_NUM_TAPS_LOG2  = NUM_TAPS_LOG2,
  parameter int G_TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     wr_data,
  input  logic                       wr_en,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [G_TAP_WIDTH-1:0]     tap_dout,
  output logic                       tap_dout_valid,
  input  logic                       tap_dout_ready,
  input  logic                       tap_done_in
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
  ,
  output logic [G_TAP_WIDTH+G_NUM_TAPS_LOG2-1:0] checksum
`endif
);
  localparam int CW = $clog2(G_TIMEOUT_CYCLES + 1);
  tap_strm_state_t            state_q, state_d;
  logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [G_TAP_WIDTH-1:0]     rd_data;
  logic                       accept, hs;
  assign accept         = enable && start && state_q == IDLE;
  assign hs             = enable && state_q == STREAM && tap_dout_ready;
  assign busy           = state_q == STREAM || state_q == WAIT_DONE;
  assign done           = state_q == DONE;
  assign tap_dout_valid = state_q == STREAM;
  assign tap_dout       = tap_dout_valid ? rd_data : '0;
  assign timeout_err    = err_q;
  // Table is frozen while a load is in flight so the streamed image is consistent
  tap_table_regs #(.W(G_TAP_WIDTH), .AW(G_NUM_TAPS_LOG2)) u_table (
    .clk   (clk),
    .reset_n(reset_n),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    err_d   = accept ? 1'b0 : err_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else
      case (state_q)
        IDLE:
          if (start) begin
            state_d = STREAM;
            idx_d   = '0;
          end
        STREAM:
          if (hs) begin
            idx_d   = idx_q + G_NUM_TAPS_LOG2'(1);
            state_d = (&idx_q) ? WAIT_DONE : STREAM;
          end
        WAIT_DONE:
          if (tap_done_in) state_d = DONE;
          else if (cnt_q == CW'(G_TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else cnt_d = cnt_q + CW'(1);
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
  localparam int SW = G_TAP_WIDTH + G_NUM_TAPS_LOG2;
  logic [SW-1:0] sum_q, sum_d;
  always_comb sum_d = accept ? '0 : hs ? sum_q + SW'(tap_dout) : sum_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_fir_tap_streamer.sv
// tb_fir_tap_streamer: directed vector table plus hand-written corner sequences for fir_tap_streamer
module tb_fir_tap_streamer;
  localparam int TW = 16, L2 = 4, N = 16, TO = 8;
  logic clk = 0, reset_n = 0, enable = 0, wr_en = 0, start = 0, rdy = 0, dni = 0;
  logic [L2-1:0] wr_addr = '0;
  logic [TW-1:0] wr_data = '0;
  logic busy, done, timeout_err, tap_dout_valid;
  logic [TW-1:0] tap_dout;
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
  logic [TW+L2-1:0] checksum;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fir_tap_streamer #(.G_TAP_WIDTH(TW), .G_NUM_TAPS_LOG2(L2), .G_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .start(start), .busy(busy), .done(done), .timeout_err(timeout_err),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid), .tap_dout_ready(rdy),
    .tap_done_in(dni)
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  typedef struct {
    logic en, st, rd, dn;
    logic bz, vl;
    logic [TW-1:0] dt;
    logic dp, er;
  } vec_t;
  vec_t tbl[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = L2'(a); wr_data = TW'(d);
    tick;
    wr_en = 0;
  endtask
  task automatic finish_load;
    logic ok;
    ok = 0; rdy = 1; dni = 1;
    for (int i = 0; i < 60 && !ok; i++) if (done) ok = 1; else tick;
    chk("done_seen", ok, 1);
    tick;
    dni = 0;
    chk("idle_after_done", busy, 0);
  endtask
  task automatic begin_load;
    start = 1;
    tick;
    start = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int beats;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", tap_dout_valid, 0);
    chk("rst_dout", tap_dout, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    reset_n = 1; enable = 1;
    tick;
    for (int k = 0; k < N; k++) wr(k, k + 1);
    // Basic load: ready high, receiver flags completion the cycle after the last beat
    tbl[0] = '{1, 1, 1, 0, 0, 0, 16'h0, 0, 0};
    for (int k = 1; k <= N; k++) tbl[k] = '{1, 0, 1, 0, 1, 1, TW'(k), 0, 0};
    tbl[17] = '{1, 0, 1, 1, 1, 0, 16'h0, 0, 0};
    tbl[18] = '{1, 0, 1, 0, 0, 0, 16'h0, 1, 0};
    tbl[19] = '{1, 0, 1, 0, 0, 0, 16'h0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      enable = tbl[i].en; start = tbl[i].st; rdy = tbl[i].rd; dni = tbl[i].dn;
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("vec%0d_valid", i), tap_dout_valid, tbl[i].vl);
      chk($sformatf("vec%0d_dout", i), tap_dout, tbl[i].dt);
      chk($sformatf("vec%0d_done", i), done, tbl[i].dp);
      chk($sformatf("vec%0d_err", i), timeout_err, tbl[i].er);
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
      if (i == 18) chk("checksum", checksum, 32'h88);
`endif
      tick;
    end
    start = 0; dni = 0;
    // Ready 1-of-3: every valid cycle must show the next expected tap, no drops or repeats
    begin_load;
    beats = 0;
    for (int c = 0; c < 100 && beats < N; c++) begin
      rdy = (c % 3 == 0);
      if (tap_dout_valid) begin
        chk("throttled_dout", tap_dout, beats + 1);
        if (rdy) beats++;
      end
      tick;
    end
    chk("throttled_count", beats, N);
    finish_load;
    // Timeout with receiver silent
    rdy = 1; dni = 0;
    begin_load;
    repeat (N) tick;
    chk("wait_entry_busy", busy, 1);
    chk("wait_entry_valid", tap_dout_valid, 0);
    for (int c = 0; c < TO; c++) begin
      chk("wait_err_low", timeout_err, 0);
      chk("wait_no_done", done, 0);
      chk("wait_busy", busy, 1);
      tick;
    end
    chk("timeout_err", timeout_err, 1);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_done", done, 0);
    tick;
    chk("err_sticky", timeout_err, 1);
    begin_load;
    chk("err_cleared", timeout_err, 0);
    chk("err_clr_valid", tap_dout_valid, 1);
    finish_load;
    // Table frozen during load
    rdy = 1;
    begin_load;
    tick;
    wr_en = 1; wr_addr = 3; wr_data = 16'h7FFF;
    tick;
    wr_en = 0;
    tick;
    chk("frozen_beat3", tap_dout, 4);
    finish_load;
    begin_load;
    repeat (3) tick;
    chk("frozen_readback", tap_dout, 4);
    finish_load;
    // Enable drop after five beats
    rdy = 1;
    begin_load;
    repeat (5) tick;
    chk("pre_drop_dout", tap_dout, 6);
    enable = 0;
    tick;
    chk("drop_busy", busy, 0);
    chk("drop_valid", tap_dout_valid, 0);
    dni = 1;
    repeat (3) begin
      chk("drop_no_done", done, 0);
      tick;
    end
    dni = 0; enable = 1;
    begin_load;
    chk("restart_valid", tap_dout_valid, 1);
    chk("restart_mem0", tap_dout, 1);
    finish_load;
    // Asynchronous reset mid-stream
    rdy = 1;
    begin_load;
    repeat (2) tick;
    #2;
    reset_n = 0;
    #1;
    chk("arst_valid", tap_dout_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dout", tap_dout, 0);
    tick;
    reset_n = 1;
    tick;
    begin_load;
    for (int k = 0; k < N; k++) begin
      chk("post_rst_valid", tap_dout_valid, 1);
      chk("post_rst_dout", tap_dout, 0);
      tick;
    end
    finish_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_tap_streamer.md
# fir_tap_streamer

Transmit side of the FIR tap-load port. Holds a host-written coefficient table in a local register array. On command, it streams the whole table over a valid/ready tap interface into `configurable_fir`/`reverb_wrapper` (`tap_din`, `tap_din_valid`, `tap_din_ready`, `tap_din_done`). It then waits for the receiver's completion flag and reports done or timeout to the control logic.

## Interface
- `G_TAP_WIDTH`, 16, coefficient width in bits.
- `G_NUM_TAPS_LOG2`, 4, log2 of table depth; must equal the receiver's NUM_STAGES_LOG2 + STAGE_DEPTH_LOG2.
- `G_TIMEOUT_CYCLES`, 1024, maximum cycles allowed in WAIT_DONE.
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block enable; 0 forces IDLE synchronously.
- `wr_addr`  in  G_NUM_TAPS_LOG2  table write address.
- `wr_data`  in  G_TAP_WIDTH  table write data.
- `wr_en`  in  1  table write strobe.
- `start`  in  1  one-cycle command to begin a load.
- `busy`  out  1  high in STREAM or WAIT_DONE.
- `done`  out  1  one-cycle pulse on successful completion.
- `timeout_err`  out  1  sticky; cleared by the next accepted start.
- `tap_dout`  out  G_TAP_WIDTH  coefficient to the receiver.
- `tap_dout_valid`  out  1  tap valid.
- `tap_dout_ready`  in  1  receiver ready.
- `tap_done_in`  in  1  receiver's load-complete flag (level).

## Operation
- The FSM has four states: IDLE, STREAM, WAIT_DONE, DONE.
- **IDLE:** `wr_en` writes `mem[wr_addr]`. A `start` with `enable`=1 does the following on the same edge:
  - clears `idx` and `timeout_err`;
  - moves to STREAM.
- **STREAM:**
  - `tap_dout_valid`=1 and `tap_dout`=`mem[idx]` (flop array, combinational read).
  - On handshake (valid & ready), `idx` increments.
  - The handshake at `idx` = 2^G_NUM_TAPS_LOG2 − 1 moves to WAIT_DONE; `idx` wraps to 0.
  - `tap_dout_valid` and `tap_dout` are held stable while ready=0.
- **WAIT_DONE:**
  - `tap_done_in`=1 moves to DONE.
  - Otherwise, when the timeout counter reaches G_TIMEOUT_CYCLES−1, set `timeout_err` and move to IDLE with no `done` pulse.
- **DONE:** `done`=1 for one cycle, then IDLE.
- Writes with `wr_en` while `busy`=1 are ignored (the table is frozen during a load). `start` while not in IDLE is ignored.
- If `wr_en` and `start` occur on the same IDLE cycle, the write lands first, so the new value is streamed.
- `enable`=0 in any state: next state IDLE, `idx` and timeout counter cleared, no `done`. The table and `timeout_err` are retained.
- The receiver must reassert `tap_done_in` only after all 2^G_NUM_TAPS_LOG2 taps are accepted. A `tap_done_in` already high on entering WAIT_DONE completes immediately.

## Timing
- Reset values: state IDLE, `mem` all 0, `idx` 0, `busy` 0, `done` 0, `timeout_err` 0, `tap_dout_valid` 0, `tap_dout` 0.
- `start` at cycle N gives `tap_dout_valid`=1 at N+1, with `tap_dout` = `mem[0]`.
- With `tap_dout_ready` held at 1, the load takes exactly 2^G_NUM_TAPS_LOG2 cycles. Back-to-back beats have no bubbles.
- The last handshake at cycle M puts the block in WAIT_DONE at M+1. If `tap_done_in` is high at M+1, `done` pulses at M+2.
- `busy`, `done` and `tap_dout_valid` are decoded from registered state; there is no combinational path from `tap_dout_ready` to `tap_dout_valid`.
- Timeout: `timeout_err` rises G_TIMEOUT_CYCLES cycles after entry to WAIT_DONE.

## Configuration
- `FIR_TAP_STREAMER_CHECKSUM_EN` defined:
  - Adds output `checksum` (G_TAP_WIDTH + G_NUM_TAPS_LOG2 bits, unsigned): the sum of all taps handshaken in the current load, treated as unsigned.
  - Cleared on accepted start; valid when `done` pulses; held until the next start; reset value 0.
- Undefined: the `checksum` port and adder are absent.

## Structure
- Shared package `tulip_dsp_pkg`:
  - state enum `tap_strm_state_t` (IDLE, STREAM, WAIT_DONE, DONE);
  - default tap width and table-depth constants shared with `configurable_fir`.
- One natural sub-module: `tap_table_regs`, the write-port flop array with combinational read and async clear.

## Test plan
- Write taps 0x0001..0x0010, start with ready held at 1, and `tap_done_in` asserted one cycle after the last beat → 16 beats in 16 consecutive cycles carrying 0x0001..0x0010 in order, and `done` pulses two cycles after the last handshake.
- Drive ready with a 1-of-3 pattern → the same 16 values with no duplicates or drops, and data stable while ready=0.
- Hold `tap_done_in`=0, with G_TIMEOUT_CYCLES=8 → `timeout_err`=1 exactly 8 cycles after WAIT_DONE entry, no `done`, back in IDLE; the next start clears `timeout_err`.
- Write `mem[3]`=0x7FFF during STREAM → the streamed tap 3 keeps its old value; a read-back via a second load still shows the old value.
- Drop `enable` after 5 beats, then restore it and start → the block returns to IDLE with no `done`, and the new load restarts at `mem[0]`.
- Deassert `reset_n` mid-stream → `tap_dout_valid` and `busy` fall immediately (asynchronously), and the table reads all zeros on the next load.
- With the checksum feature enabled and taps 0x0001..0x0010 → `checksum` = 0x0088 at `done`.
